// File: rtl/nes_pkg.sv
// Shared constants for the NES joypad bridge: button bit positions, open-bus
// value and the default HID keycode for each button.
package nes_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam logic [7:0] OPEN_BUS = 8'h40;

  localparam logic [7:0] DEF_KEY_A      = 8'h0E;
  localparam logic [7:0] DEF_KEY_B      = 8'h0D;
  localparam logic [7:0] DEF_KEY_SELECT = 8'h0A;
  localparam logic [7:0] DEF_KEY_START  = 8'h0B;
  localparam logic [7:0] DEF_KEY_UP     = 8'h1A;
  localparam logic [7:0] DEF_KEY_DOWN   = 8'h16;
  localparam logic [7:0] DEF_KEY_LEFT   = 8'h04;
  localparam logic [7:0] DEF_KEY_RIGHT  = 8'h07;

  // A zero key never matches, so empty keycode slots cannot press anything.
  function automatic logic key_hit(input logic [31:0] keycode, input logic [7:0] key);
    return (key != 8'h00) &&
           ((keycode[7:0] == key) || (keycode[15:8] == key) ||
            (keycode[23:16] == key) || (keycode[31:24] == key));
  endfunction

endpackage

// File: rtl/nes_key_decode.sv
// Combinational keycode-to-button mapping with opposing-direction cancellation.
module nes_key_decode
  import nes_pkg::*;
#(
  parameter logic [7:0] KEY_A      = DEF_KEY_A,
  parameter logic [7:0] KEY_B      = DEF_KEY_B,
  parameter logic [7:0] KEY_SELECT = DEF_KEY_SELECT,
  parameter logic [7:0] KEY_START  = DEF_KEY_START,
  parameter logic [7:0] KEY_UP     = DEF_KEY_UP,
  parameter logic [7:0] KEY_DOWN   = DEF_KEY_DOWN,
  parameter logic [7:0] KEY_LEFT   = DEF_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT  = DEF_KEY_RIGHT
) (
  input  logic [31:0] keycode,
  output logic [7:0]  buttons
);

  logic up, down, left, right;

  always_comb begin
    up    = key_hit(keycode, KEY_UP);
    down  = key_hit(keycode, KEY_DOWN);
    left  = key_hit(keycode, KEY_LEFT);
    right = key_hit(keycode, KEY_RIGHT);

    buttons             = '0;
    buttons[BTN_A]      = key_hit(keycode, KEY_A);
    buttons[BTN_B]      = key_hit(keycode, KEY_B);
    buttons[BTN_SELECT] = key_hit(keycode, KEY_SELECT);
    buttons[BTN_START]  = key_hit(keycode, KEY_START);
    // Opposing directions held together cancel out, as on a real pad.
    buttons[BTN_UP]     = up & ~down;
    buttons[BTN_DOWN]   = down & ~up;
    buttons[BTN_LEFT]   = left & ~right;
    buttons[BTN_RIGHT]  = right & ~left;
  end

endmodule

// File: rtl/nes_joypad.sv
// NES controller port emulation: registers decoded keyboard buttons and serves
// them through the $4016 strobe / serial-read protocol.
module nes_joypad
  import nes_pkg::*;
#(
  parameter logic [7:0] KEY_A      = DEF_KEY_A,
  parameter logic [7:0] KEY_B      = DEF_KEY_B,
  parameter logic [7:0] KEY_SELECT = DEF_KEY_SELECT,
  parameter logic [7:0] KEY_START  = DEF_KEY_START,
  parameter logic [7:0] KEY_UP     = DEF_KEY_UP,
  parameter logic [7:0] KEY_DOWN   = DEF_KEY_DOWN,
  parameter logic [7:0] KEY_LEFT   = DEF_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT  = DEF_KEY_RIGHT
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] keycode_export,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  input  logic        rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [7:0]  buttons
);

  logic [7:0] btn_comb;
  logic [7:0] buttons_q;
  logic       strobe_q, strobe_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q;
  logic       port1_rd, serial_bit;
  logic       unused_wr_data;

  assign unused_wr_data = ^wr_data[7:1];

  nes_key_decode #(
    .KEY_A      (KEY_A),
    .KEY_B      (KEY_B),
    .KEY_SELECT (KEY_SELECT),
    .KEY_START  (KEY_START),
    .KEY_UP     (KEY_UP),
    .KEY_DOWN   (KEY_DOWN),
    .KEY_LEFT   (KEY_LEFT),
    .KEY_RIGHT  (KEY_RIGHT)
  ) u_decode (
    .keycode (keycode_export),
    .buttons (btn_comb)
  );

  always_comb begin
    port1_rd   = rd_en && !rd_addr;
    serial_bit = strobe_q ? buttons_q[BTN_A] : shift_q[0];

    strobe_d = wr_en ? wr_data[0] : strobe_q;

    // Reads see pre-write state; a reload beats a shift in the same cycle.
    shift_d = shift_q;
    if ((wr_en && wr_data[0]) || strobe_q) begin
      shift_d = buttons_q;
    end else if (port1_rd) begin
      shift_d = {1'b1, shift_q[7:1]};
    end

    rd_cnt_d = rd_cnt_q;
    if (wr_en) begin
      rd_cnt_d = 4'd0;
    end else if (port1_rd && !strobe_q && (rd_cnt_q < 4'd8)) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
    end

    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_addr ? OPEN_BUS : (OPEN_BUS | {7'b0, serial_bit});
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      buttons_q  <= '0;
      strobe_q   <= 1'b0;
      shift_q    <= '0;
      rd_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      buttons_q  <= btn_comb;
      strobe_q   <= strobe_d;
      shift_q    <= shift_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign buttons  = buttons_q;

  a_cnt_sat: assert property (@(posedge clk_clk) rd_cnt_q <= 4'd8);

endmodule

// File: tb/tb_nes_joypad.sv
// Directed self-checking bench for nes_joypad.
module tb_nes_joypad;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [31:0] keycode_export = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        rd_en = 1'b0;
  logic        rd_addr = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  buttons;

  int checks = 0;
  int fails  = 0;

  always #5 clk_clk = ~clk_clk;

  nes_joypad dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .keycode_export (keycode_export),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .buttons        (buttons)
  );

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic do_read(input logic addr, output logic [7:0] data, output logic valid);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en   = 1'b0;
    rd_addr = 1'b0;
    data    = rd_data;
    valid   = rd_valid;
  endtask

  // Upper data bits are deliberately noisy: only bit 0 may matter.
  task automatic write_strobe(input logic s);
    wr_en   = 1'b1;
    wr_data = s ? 8'hF1 : 8'hFE;
    tick();
    wr_en   = 1'b0;
    wr_data = 8'h00;
  endtask

  task automatic latch();
    write_strobe(1'b1);
    write_strobe(1'b0);
  endtask

  task automatic test_reset();
    reset_reset_n  = 1'b0;
    keycode_export = 32'h0000_000E;
    wr_en = 1'b1; wr_data = 8'h01; rd_en = 1'b1;
    tick(); tick();
    checks++;
    if (buttons !== 8'h00) begin
      fails++; $display("FAIL reset_buttons: got %h want 00", buttons);
    end
    checks++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
      fails++; $display("FAIL reset_rd: got data %h valid %b want 00 0", rd_data, rd_valid);
    end
    checks++;
    if (dut.strobe_q !== 1'b0 || dut.shift_q !== 8'h00 || dut.rd_cnt_q !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: got strobe %b shift %h cnt %0d want 0 00 0",
               dut.strobe_q, dut.shift_q, dut.rd_cnt_q);
    end
    wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
    keycode_export = '0;
    reset_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_serial_a();
    logic [7:0] d;
    logic       v;
    keycode_export = 32'h0000_000E;
    tick();
    latch();
    for (int i = 0; i < 9; i++) begin
      do_read(1'b0, d, v);
      checks++;
      if (d !== ((i == 0 || i == 8) ? 8'h41 : 8'h40) || v !== 1'b1) begin
        fails++;
        $display("FAIL serial_a_read%0d: got %h valid %b want %h 1", i + 1, d, v,
                 (i == 0 || i == 8) ? 8'h41 : 8'h40);
      end
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      fails++; $display("FAIL valid_one_cycle: got %b want 0", rd_valid);
    end
    checks++;
    if (dut.rd_cnt_q !== 4'd8) begin
      fails++; $display("FAIL cnt_saturate: got %0d want 8", dut.rd_cnt_q);
    end
  endtask

  task automatic test_opposing();
    keycode_export = 32'h1A16_0407;
    tick();
    checks++;
    if (buttons !== 8'h00) begin
      fails++; $display("FAIL opposing_all: got %h want 00", buttons);
    end
    keycode_export = 32'h0000_0B1A;
    tick();
    checks++;
    if (buttons !== 8'h18) begin
      fails++; $display("FAIL up_start: got %h want 18", buttons);
    end
    keycode_export = 32'h0D0E_0A00;
    tick();
    checks++;
    if (buttons !== 8'h07) begin
      fails++; $display("FAIL high_slots: got %h want 07", buttons);
    end
  endtask

  task automatic test_strobe_track();
    logic [7:0]  d;
    logic        v;
    logic [31:0] prev;
    keycode_export = 32'h0000_000E;
    write_strobe(1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      prev = keycode_export;
      keycode_export = (i % 2 == 0) ? 32'h0 : 32'h0000_000E;
      do_read(1'b0, d, v);
      checks++;
      if (d !== ((prev == 32'h0000_000E) ? 8'h41 : 8'h40)) begin
        fails++; $display("FAIL strobe_track%0d: got %h want %h", i, d,
                          (prev == 32'h0000_000E) ? 8'h41 : 8'h40);
      end
    end
    checks++;
    if (dut.rd_cnt_q !== 4'd0) begin
      fails++; $display("FAIL strobe_cnt: got %0d want 0", dut.rd_cnt_q);
    end
    write_strobe(1'b0);
  endtask

  task automatic test_latch_hold();
    logic [7:0] d;
    logic       v;
    keycode_export = 32'h0000_000E;
    tick();
    latch();
    keycode_export = 32'h0000_000D;
    tick(); tick();
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h41) begin
      fails++; $display("FAIL hold_read1: got %h want 41", d);
    end
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h40) begin
      fails++; $display("FAIL hold_read2: got %h want 40", d);
    end
    checks++;
    if (buttons !== 8'h02) begin
      fails++; $display("FAIL hold_buttons: got %h want 02", buttons);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       v;
    keycode_export = 32'h0000_0D0E;
    tick();
    latch();
    do_read(1'b0, d, v);
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h41) begin
      fails++; $display("FAIL b2b_read2: got %h want 41", d);
    end
    rd_en = 1'b1; rd_addr = 1'b0; wr_en = 1'b1; wr_data = 8'h01;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    checks++;
    if (rd_data !== 8'h40 || dut.strobe_q !== 1'b1) begin
      fails++; $display("FAIL b2b_same_cycle: got %h strobe %b want 40 1", rd_data, dut.strobe_q);
    end
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h41) begin
      fails++; $display("FAIL b2b_after_write: got %h want 41", d);
    end
    write_strobe(1'b0);
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h41) begin
      fails++; $display("FAIL b2b_a: got %h want 41", d);
    end
    do_read(1'b1, d, v);
    checks++;
    if (d !== 8'h40 || v !== 1'b1) begin
      fails++; $display("FAIL port2: got %h valid %b want 40 1", d, v);
    end
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h41) begin
      fails++; $display("FAIL port2_noshift_b: got %h want 41", d);
    end
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h40 || dut.rd_cnt_q !== 4'd3) begin
      fails++; $display("FAIL b2b_select: got %h cnt %0d want 40 3", d, dut.rd_cnt_q);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       v;
    keycode_export = 32'h0000_0D0E;
    tick();
    latch();
    do_read(1'b0, d, v);
    do_read(1'b0, d, v);
    do_read(1'b0, d, v);
    reset_reset_n = 1'b0;
    tick();
    checks++;
    if (buttons !== 8'h00 || rd_data !== 8'h00 || rd_valid !== 1'b0) begin
      fails++; $display("FAIL mid_reset: got btn %h data %h valid %b want 00 00 0",
                        buttons, rd_data, rd_valid);
    end
    reset_reset_n = 1'b1;
    tick();
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h40) begin
      fails++; $display("FAIL post_reset_read1: got %h want 40", d);
    end
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h40) begin
      fails++; $display("FAIL post_reset_read2: got %h want 40", d);
    end
    latch();
    do_read(1'b0, d, v);
    checks++;
    if (d !== 8'h41) begin
      fails++; $display("FAIL post_reset_relatch: got %h want 41", d);
    end
  endtask

  initial begin
    test_reset();
    test_serial_a();
    test_opposing();
    test_strobe_track();
    test_latch_hold();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/nes_joypad.md
NES_JOYPAD -- requirements
Module: nes_joypad

Interface
REQ-001 SHALL have parameter KEY_A, default 8'h0E ('K'), HID usage mapped to button A.
REQ-002 SHALL have parameter KEY_B, default 8'h0D ('J'), mapped to B.
REQ-003 SHALL have parameters KEY_SELECT 8'h0A ('G'), KEY_START 8'h0B ('H'), KEY_UP 8'h1A ('W'), KEY_DOWN 8'h16 ('S'), KEY_LEFT 8'h04 ('A') and KEY_RIGHT 8'h07 ('D'), each mapped to its named button.
REQ-004 SHALL have port clk_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port keycode_export, input, 32 bits: four HID keycodes in bytes [7:0], [15:8], [23:16] and [31:24]; 8'h00 means empty slot.
REQ-007 SHALL have port wr_en, input, 1 bit: single-cycle CPU write to $4016.
REQ-008 SHALL have port wr_data, input, 8 bits: write data; only bit 0 (strobe) is used.
REQ-009 SHALL have port rd_en, input, 1 bit: single-cycle CPU read.
REQ-010 SHALL have port rd_addr, input, 1 bit: 0 selects $4016 (port 1), 1 selects $4017 (port 2).
REQ-011 SHALL have port rd_data, output, 8 bits: read result.
REQ-012 SHALL have port rd_valid, output, 1 bit: rd_data qualifier.
REQ-013 SHALL have port buttons, output, 8 bits: current button vector {Right,Left,Down,Up,Start,Select,B,A}, bit 0 = A, for LEDs and debug.

Function
REQ-014 A button SHALL be pressed when any of the four keycode bytes equals its parameter; matching is a combinational compare, and the result is registered into buttons with 1-cycle latency.
REQ-015 If Up and Down are both pressed, both SHALL read 0; the same rule SHALL apply to Left and Right.
REQ-016 On wr_en, the strobe register SHALL load wr_data[0].
REQ-017 While strobe=1, the 8-bit shift register SHALL reload from buttons every cycle.
REQ-018 A read of port 1 while strobe=1 SHALL return the A bit and SHALL NOT shift.
REQ-019 While strobe=0, each rd_en with rd_addr=0 SHALL return shift[0], then shift right with a 1 filled into bit 7.
REQ-020 As a consequence of REQ-019, reads 1..8 after latch SHALL return A, B, Select, Start, Up, Down, Left, Right, and read 9 onward SHALL return 1.
REQ-021 rd_data SHALL be {7'b0100000, bit} (open-bus 0x40 plus serial bit), registered, with rd_valid high for exactly the one cycle after rd_en.
REQ-022 A read with rd_addr=1 SHALL return 8'h40 (no second controller) and SHALL NOT affect the shift register.
REQ-023 When rd_en and wr_en occur in the same cycle, the read SHALL use the pre-write strobe and shift state; the write is then applied, and a reload (new strobe=1) SHALL take priority over the shift.
REQ-024 A 4-bit read counter SHALL clear on any strobe write and saturate at 8, counting port-1 reads while strobe=0; it is internal, for assertion use only.
REQ-025 A keycode change during shifting SHALL NOT alter the latched shift register until the next strobe=1.

Reset
REQ-026 While reset_reset_n=0 at a clock edge, strobe, shift register, buttons, read counter, rd_data and rd_valid SHALL all be 0.
REQ-027 After reset, reads SHALL return 8'h40 until the first strobe cycle loads the shift register; a reset mid-sequence SHALL abandon the sequence.

Structure
REQ-028 A shared package nes_pkg SHALL hold the button bit-index constants (BTN_A=0 .. BTN_RIGHT=7), OPEN_BUS=8'h40 and the default keycode constants.
REQ-029 One sub-module, nes_key_decode, SHALL contain the combinational keycode-to-button mapping and the opposing-direction rule; nes_joypad SHALL contain all sequential logic.

Verification
REQ-030 keycode=32'h0000_000E, write 1 then 0, eight reads -> rd_data 41,40,40,40,40,40,40,40, then read 9 -> 41.
REQ-031 keycode=32'h1A16_0407 (Up, Down, Left, Right) -> buttons=8'h00; keycode=32'h0000_0B1A -> buttons=8'h18.
REQ-032 Strobe held 1, keycode toggles 0E/00, read each cycle -> rd_data tracks A with 1-cycle button latency and the counter stays 0.
REQ-033 Strobe 0 after latching A, keycode changed to 0D, two reads -> 41 then 40 (latched value kept).
REQ-034 rd_en and wr_en(1) in the same cycle after two reads -> the read returns the old shift[0], and the next read returns the A bit; rd_addr=1 read -> 40, with no shift.
REQ-035 Reset asserted after 3 reads -> all outputs 0, and the next read -> 40 until the strobe is rewritten.
